multicycle_ctrl: RTL

Multi-cycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, using the instruction-format class flags produced by the instruction decoder. It drives the enables for the instruction register, PC, register file and data-memory port, and handles the instruction- and data-memory handshakes. Illegal instructions and memory timeouts put it in a sticky trap state.

---
 rtl/multicycle_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Optional build macro: MULTICYCLE_CTRL_INSTRET_EN enables the 32-bit
// retired-instruction counter; without it instret is tied to 0.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic [6:0]  opcode,
  input  logic        is_b,
  input  logic        is_i,
  input  logic        is_j,
  input  logic        is_r,
  input  logic        is_s,
  input  logic        is_u,
  input  logic        incorrect,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  localparam logic [6:0]  OP_LOAD = 7'b0000011;
  localparam logic [6:0]  OP_JALR = 7'b1100111;

  state_t      state, state_nxt;
  logic [15:0] to_cnt;
  logic [6:0]  op_q;
  logic        b_q, j_q, s_q;
  logic [1:0]  cause_q, cause_nxt;
  logic        is_load, is_jalr, any_cls;
  logic        imem_req_c, ir_we_c, dmem_req_c, dmem_we_c;
  logic        rf_we_c, pc_we_c, pc_sel_c, retire_c;

  assign is_load = (op_q == OP_LOAD);
  assign is_jalr = (op_q == OP_JALR);
  assign any_cls = is_b | is_i | is_j | is_r | is_s | is_u;

  // State register, trap cause and decoded-class latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      cause_q <= 2'b00;
      op_q    <= '0;
      b_q     <= 1'b0;
      j_q     <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
      if (state == S_DECODE) begin
        op_q <= opcode;
        b_q  <= is_b;
        j_q  <= is_j;
        s_q  <= is_s;
      end
    end
  end

  // Memory-wait timeout: restarts on any state change, counts stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (state_nxt != state)
      to_cnt <= '0;
    else if ((state == S_FETCH && !imem_ready) || (state == S_MEM && !dmem_ready))
      to_cnt <= to_cnt + 16'd1;
  end

  // Next-state and strobe decode; ready at the limit beats the timeout
  always_comb begin
    state_nxt  = state;
    cause_nxt  = cause_q;
    imem_req_c = 1'b0;
    ir_we_c    = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    rf_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel_c   = 1'b0;
    retire_c   = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_we_c   = 1'b1;
          state_nxt = S_DECODE;
        end else if (to_cnt == TO_LIM) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b10;
        end
      end
      S_DECODE: begin
        if (incorrect || !any_cls) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b01;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (b_q) begin
          pc_we_c   = 1'b1;
          pc_sel_c  = branch_taken;
          retire_c  = 1'b1;
          state_nxt = S_FETCH;
        end else if (is_load || s_q) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = s_q;
        if (dmem_ready) begin
          if (s_q) begin
            pc_we_c   = 1'b1;
            retire_c  = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (to_cnt == TO_LIM) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b11;
        end
      end
      S_WB: begin
        rf_we_c   = 1'b1;
        pc_we_c   = 1'b1;
        pc_sel_c  = j_q | is_jalr;
        retire_c  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_TRAP: state_nxt = S_TRAP;
      default: begin
        state_nxt = S_TRAP;
        cause_nxt = 2'b01;
      end
    endcase
  end

  // Strobes are forced low while reset is held so nothing leaks mid-reset
  assign imem_req   = imem_req_c & rst_n;
  assign ir_we      = ir_we_c    & rst_n;
  assign dmem_req   = dmem_req_c & rst_n;
  assign dmem_we    = dmem_we_c  & rst_n;
  assign rf_we      = rf_we_c    & rst_n;
  assign pc_we      = pc_we_c    & rst_n;
  assign pc_sel     = pc_sel_c   & rst_n;
  assign retire     = retire_c   & rst_n;
  assign trap       = (state == S_TRAP);
  assign trap_cause = cause_q;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [31:0] instret_q;

  // Retired-instruction counter; wraps naturally, idle in TRAP (no retire there)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instret_q <= '0;
    else if (retire_c && state != S_TRAP)
      instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule
